// File: rtl/serial_alu.sv
// Bit-serial ALU sequencer: one slice evaluation per clock with a stored carry,
// assembling a WIDTH-bit result LSB first behind a start/done handshake.
module serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ALU_control_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] src1_reg, src2_reg, shift_reg;
  logic [3:0]       ctrl_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;

  logic             a_bit, b_bit, sum_bit, carry_out, res_bit;
  logic             ovf_bit, set_bit, is_arith;
  logic [WIDTH-1:0] word, final_res;

  // Single ALU slice for bit cnt_reg; ovf/set are only meaningful at the MSB.
  always_comb begin
    a_bit     = ctrl_reg[3] ^ src1_reg[cnt_reg];
    b_bit     = ctrl_reg[2] ^ src2_reg[cnt_reg];
    sum_bit   = a_bit ^ b_bit ^ carry_reg;
    carry_out = (a_bit & b_bit) | (a_bit & carry_reg) | (b_bit & carry_reg);
    is_arith  = ctrl_reg[1];
    case (ctrl_reg[1:0])
      2'b00:   res_bit = a_bit & b_bit;
      2'b01:   res_bit = a_bit | b_bit;
      2'b10:   res_bit = sum_bit;
      default: res_bit = 1'b0;
    endcase
    ovf_bit   = carry_reg ^ carry_out;
    set_bit   = sum_bit ^ ovf_bit;
    word      = {res_bit, shift_reg[WIDTH-1:1]};
    final_res = (ctrl_reg[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, set_bit} : word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      src1_reg   <= '0;
      src2_reg   <= '0;
      ctrl_reg   <= '0;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            src1_reg  <= src1_i;
            src2_reg  <= src2_i;
            ctrl_reg  <= ALU_control_i;
            cnt_reg   <= '0;
            carry_reg <= ALU_control_i[2];
            busy_o    <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          shift_reg <= word;
          cnt_reg   <= cnt_reg + 1'b1;
          if (is_arith) carry_reg <= carry_out;
          if (cnt_reg == LAST_BIT) begin
            result_o   <= final_res;
            zero_o     <= (final_res == '0);
            cout_o     <= is_arith & carry_out;
            overflow_o <= is_arith & ovf_bit;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          done_o    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: a word-level reference model checked every cycle,
// plus directed operations with literal expected results and latency.
module tb_serial_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_i, start_i;
  logic [W-1:0]  src1_i, src2_i;
  logic [3:0]    ALU_control_i;
  logic [W-1:0]  result_o;
  logic          zero_o, cout_o, overflow_o, busy_o, done_o;

  int tests_run = 0;
  int tests_failed = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .src1_i(src1_i), .src2_i(src2_i), .ALU_control_i(ALU_control_i),
    .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o),
    .overflow_o(overflow_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Word-level reference: returns {overflow, cout, result}.
  function automatic logic [W+1:0] model_op(input logic [3:0] c,
                                            input logic [W-1:0] x, y);
    logic [W-1:0] xa, yb, res;
    logic [W:0]   s;
    logic         ov, co;
    xa = c[3] ? ~x : x;
    yb = c[2] ? ~y : y;
    s  = {1'b0, xa} + {1'b0, yb} + {{W{1'b0}}, c[2]};
    ov = (xa[W-1] == yb[W-1]) && (s[W-1] != xa[W-1]);
    co = s[W];
    case (c[1:0])
      2'b00:   begin res = xa & yb; ov = 1'b0; co = 1'b0; end
      2'b01:   begin res = xa | yb; ov = 1'b0; co = 1'b0; end
      2'b10:   res = s[W-1:0];
      default: res = {{(W-1){1'b0}}, s[W-1] ^ ov};
    endcase
    return {ov, co, res};
  endfunction

  // Model state: 0 idle, 1 running (m_left edges to go), 2 done cycle.
  int           m_state = 0;
  int           m_left = 0;
  logic [W+1:0] m_pend = '0;
  logic [W-1:0] m_res = '0;
  logic         m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_i) begin
      m_state = 0; m_res = '0; m_z = 0; m_c = 0; m_v = 0;
    end else begin
      case (m_state)
        0: if (start_i) begin
             m_pend = model_op(ALU_control_i, src1_i, src2_i);
             m_left = W;
             m_state = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_res = m_pend[W-1:0];
               m_c = m_pend[W];
               m_v = m_pend[W+1];
               m_z = (m_res == '0);
               m_state = 2;
             end
           end
        default: m_state = 0;
      endcase
    end
    #1;
    chk("cyc_result", result_o, m_res);
    chk("cyc_zero", W'(zero_o), W'(m_z));
    chk("cyc_cout", W'(cout_o), W'(m_c));
    chk("cyc_ovf", W'(overflow_o), W'(m_v));
    chk("cyc_busy", W'(busy_o), W'(m_state == 1));
    chk("cyc_done", W'(done_o), W'(m_state == 2));
  end

  // Drive one operation from idle, check latency and literal results.
  task automatic run_op(input string name, input logic [3:0] c,
                        input logic [W-1:0] x, y, er,
                        input logic ez, ec, ev);
    int lat;
    @(negedge clk);
    start_i = 1; ALU_control_i = c; src1_i = x; src2_i = y;
    @(negedge clk);
    start_i = 0; src1_i = ~x; src2_i = ~y;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done_o) begin lat = i; break; end
    end
    chk({name, "_latency"}, W'(lat), W'(W));
    chk({name, "_result"}, result_o, er);
    chk({name, "_flags"}, {29'b0, ez, ec, ev}, {29'b0, zero_o, cout_o, overflow_o});
    $display("[TB] %s ctrl=%b a=0x%08h b=0x%08h -> res=0x%08h z=%0b c=%0b v=%0b",
             name, c, x, y, result_o, zero_o, cout_o, overflow_o);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    logic [3:0] ctrls [4] = '{4'b0010, 4'b0110, 4'b0111, 4'b1100};
    rst_i = 1; start_i = 0; src1_i = '0; src2_i = '0; ALU_control_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", result_o, '0);
    chk("reset_ctl", W'({busy_o, done_o, zero_o, cout_o, overflow_o}), '0);
    rst_i = 0;

    run_op("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1);
    run_op("sub_eq",   4'b0110, 32'd5,        32'd5,        32'h00000000, 1, 1, 0);
    run_op("sub_neg",  4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF, 0, 0, 0);
    run_op("slt_m1_1", 4'b0111, 32'hFFFFFFFF, 32'd1,        32'h00000001, 0, 1, 0);
    run_op("slt_1_m1", 4'b0111, 32'd1,        32'hFFFFFFFF, 32'h00000000, 1, 0, 0);
    run_op("slt_ovf",  4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 1, 1);
    run_op("nor",      4'b1100, 32'h0F0F0F0F, 32'h00000000, 32'hF0F0F0F0, 0, 0, 0);
    run_op("and",      4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 0, 0, 0);
    run_op("nand_one", 4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 0, 0);
    run_op("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0);

    // start held high with operands changing every cycle
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      start_i = 1; src1_i = $urandom; src2_i = $urandom;
      ALU_control_i = ctrls[i % 4];
      @(negedge clk);
      if (done_o) pulses++;
    end
    start_i = 0;
    for (int i = 0; i < 40; i++) begin
      src1_i = $urandom; src2_i = $urandom;
      @(negedge clk);
      if (done_o) pulses++;
    end
    chk("held_start_pulses", W'(pulses), 32'd3);
    $display("[TB] held_start done pulses=%0d", pulses);

    // reset mid-RUN at edge 10, restart at edge 12
    start_i = 1; ALU_control_i = 4'b0010; src1_i = 32'd100; src2_i = 32'd23;
    @(negedge clk);
    start_i = 0;
    repeat (9) @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    chk("midrst_result", result_o, '0);
    chk("midrst_ctl", W'({busy_o, done_o, zero_o, cout_o, overflow_o}), '0);
    $display("[TB] mid_run_reset busy=%0b done=%0b res=0x%08h", busy_o, done_o, result_o);
    run_op("after_rst", 4'b0110, 32'd100, 32'd23, 32'd77, 0, 1, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial 32-bit ALU sequencer that computes one result bit per clock using a single-bit slice datapath with a stored carry. It is the initiator side of the ALU slice interface: it generates A_invert, B_invert, operation, cin and set for bit position i, and assembles the 32 slice results into a word. It sits beside the datapath as a low-area alternative to the 32-slice ripple ALU and uses a start/done handshake.

## Interface
- WIDTH, 32, operand and result width; the counter is sized to $clog2(WIDTH)
- clk_i  input  1  rising-edge clock
- rst_i  input  1  synchronous reset, active-high
- start_i  input  1  request a new operation; sampled only in IDLE
- src1_i  input  WIDTH  operand A; latched on start acceptance
- src2_i  input  WIDTH  operand B; latched on start acceptance
- ALU_control_i  input  4  bit3 = A_invert, bit2 = B_invert, bits[1:0] = operation (00 AND, 01 OR, 10 ADD, 11 SLT); latched on start acceptance
- result_o  output  WIDTH  final result; holds until the next completion
- zero_o  output  1  result_o == 0; registered together with result_o
- cout_o  output  1  final carry out for operation 10/11; 0 for 00/01
- overflow_o  output  1  signed overflow for 10/11; 0 for 00/01
- busy_o  output  1  high in RUN
- done_o  output  1  one-cycle pulse in DONE

Clock is clk_i. Reset is synchronous and active-high.

## Operation
- FSM states: IDLE, RUN, DONE. Reset goes to IDLE.
- IDLE: when start_i = 1 at an edge, latch the operands and the control word, set bit counter cnt = 0 and carry = B_invert, then go to RUN. If start_i = 0, stay in IDLE.
- RUN: each edge processes bit cnt.
  - a = A_invert ? ~src1[cnt] : src1[cnt]
  - b = B_invert ? ~src2[cnt] : src2[cnt]
  - sum = a ^ b ^ carry
  - AND gives a & b, OR gives a | b, ADD gives sum, SLT gives 0 (bit 0 is fixed up later).
  - For operation 10/11, carry <= majority(a, b, carry). For 00/01, carry holds.
  - The result bit shifts into an internal shift register, LSB first. cnt increments.
- Completion edge (cnt == WIDTH-1):
  - overflow = carry-into-MSB ^ carry-out-of-MSB
  - set = sum_MSB ^ overflow
  - For SLT, result_o <= {0..., set}. Otherwise result_o <= the assembled word.
  - zero_o, cout_o and overflow_o are updated on the same edge.
  - Next state is DONE.
- DONE: always returns to IDLE on the next edge. start_i is ignored in DONE.
- start_i is ignored in RUN and DONE. It is not queued.
- Operand inputs may change freely after acceptance without affecting the in-flight operation.
- Every 4-bit control code is legal. Examples:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
  - 1101 NAND
- Arithmetic is modulo 2^WIDTH. SLT is a signed compare via A + ~B + 1.

## Timing
- Reset values: result_o = 0, zero_o = 0, cout_o = 0, overflow_o = 0, busy_o = 0, done_o = 0, state IDLE, cnt = 0, carry = 0.
- Acceptance at edge N gives busy_o = 1 from N to N+WIDTH.
- Bits 0..WIDTH-1 are processed at edges N+1..N+WIDTH.
- Outputs update at edge N+WIDTH. done_o is high for exactly that one cycle; busy_o is low in it.
- Earliest next acceptance is edge N+WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- rst_i asserted in any state, including mid-RUN, applies the reset values at that edge. No done_o pulse is produced for the aborted operation. Reset has priority over start_i.
- result_o, zero_o, cout_o and overflow_o change only on a completion edge or on reset.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, start at edge 0 -> done_o high after edge 32; result_o = 0x80000000, overflow_o = 1, cout_o = 0, zero_o = 0.
- SUB (0110) 5 - 5 -> result_o = 0, zero_o = 1, cout_o = 1, overflow_o = 0. Also 0 - 1 -> result_o = 0xFFFFFFFF, cout_o = 0.
- SLT (0111):
  - 0xFFFFFFFF vs 1 -> result_o = 1.
  - 1 vs 0xFFFFFFFF -> result_o = 0, zero_o = 1.
  - 0x80000000 vs 0x7FFFFFFF -> result_o = 1 (overflow case).
- NOR (1100) 0x0F0F0F0F, 0 -> result_o = 0xF0F0F0F0. AND 0xFF00FF00 & 0x0FF00FF0 -> result_o = 0x0F000F00, cout_o = 0.
- start_i held high continuously with changing operands -> only operations accepted in IDLE run. Accepts occur at edges 0, 34, 68. Operand changes mid-RUN do not alter results. Exactly one done_o pulse per operation.
- rst_i pulsed at edge 10 of a RUN -> all outputs return to reset values at that edge, with no done_o pulse. A new start at edge 12 completes normally at edge 44.
